// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - iterative AES MixColumns, COLS_PER_CYCLE columns mixed per clock
// Optional InvMixColumns mode selected per state by inv, compiled in with MIXCOL_INV_EN.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward column: rows of {2,3,1,1} rotated right per output row.
  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a, b, e, d;
    {a, b, e, d} = c;
    return {xtime(a) ^ xtime(b) ^ b ^ e ^ d,
            a ^ xtime(b) ^ xtime(e) ^ e ^ d,
            a ^ b ^ xtime(e) ^ xtime(d) ^ d,
            xtime(a) ^ a ^ b ^ e ^ xtime(d)};
  endfunction

`ifdef MIXCOL_INV_EN
  // Inverse column: rows of {14,11,13,9}, multiples built from chained xtime.
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] x [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    {x[0], x[1], x[2], x[3]} = c;
    for (int k = 0; k < 4; k++) begin
      x2[k]  = xtime(x[k]);
      x4[k]  = xtime(x2[k]);
      x8[k]  = xtime(x4[k]);
      m9[k]  = x8[k] ^ x[k];
      m11[k] = x8[k] ^ x2[k] ^ x[k];
      m13[k] = x8[k] ^ x4[k] ^ x[k];
      m14[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction
`endif

  state_t         state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   src_q, src_d;
  logic [127:0]   res_q, res_d;
  logic           rdy_idle_q, rdy_idle_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           accept;
  logic           last_step;
  logic [1:0]     idx;
  logic [6:0]     base;
  logic [31:0]    col_in;
  logic [31:0]    mixed;

`ifdef MIXCOL_INV_EN
  logic           inv_q, inv_d;
`else
  logic           unused_inv;
  assign unused_inv = inv;
`endif

  // Accept from IDLE, or from DONE when the result leaves on the same edge.
  assign in_ready  = rdy_idle_q | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last_step = (({1'b0, col_q} + 3'(COLS_PER_CYCLE)) == 3'd4);

  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign busy      = busy_q;

  // Next-state, column mixing and registered-output decode.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    src_d   = src_q;
    res_d   = res_q;
    idx     = 2'd0;
    base    = 7'd0;
    col_in  = 32'd0;
    mixed   = 32'd0;
`ifdef MIXCOL_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d   = in_data;
          col_d   = 2'd0;
          state_d = BUSY;
`ifdef MIXCOL_INV_EN
          inv_d   = inv;
`endif
        end
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          idx    = col_q + 2'(k);
          // Column idx occupies bits [127-32*idx -: 32]; ~idx equals 3-idx.
          base   = {~idx, 5'b00000};
          col_in = src_q[base +: 32];
`ifdef MIXCOL_INV_EN
          mixed  = inv_q ? mix_inv(col_in) : mix_fwd(col_in);
`else
          mixed  = mix_fwd(col_in);
`endif
          res_d[base +: 32] = mixed;
        end
        col_d = col_q + 2'(COLS_PER_CYCLE);
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            src_d   = in_data;
            col_d   = 2'd0;
            state_d = BUSY;
`ifdef MIXCOL_INV_EN
            inv_d   = inv;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_idle_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == BUSY);
  end

  // State and datapath registers; reset discards any in-flight state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      src_q       <= 128'd0;
      res_q       <= 128'd0;
      rdy_idle_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MIXCOL_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      src_q       <= src_d;
      res_q       <= res_d;
      rdy_idle_q  <= rdy_idle_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MIXCOL_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

endmodule
